// File: rtl/imem_responder.sv
// Instruction-memory responder for the LEGv8 fetch stage: one outstanding fetch,
// WAIT wait states, registered instruction return, and a side load port.
module imem_responder #(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [N-1:0]             imem_addr_F,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     stall_F,
  output logic                     instr_valid,
  output logic [31:0]              instr_D,
  output logic                     fault
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [N-1:0] addr_q, addr_n;
  logic [31:0] mem [DEPTH];
  logic        capture;
  logic        rd_fault;
  logic [31:0] rd_word;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    unique case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          addr_n = imem_addr_F;
          if (WAIT == 0) begin
            state_n = S_RESP;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 4'(WAIT);
          end
        end
      end
      S_WAIT: begin
        if (flush)              state_n = S_IDLE;
        else if (cnt == 4'd1)   state_n = S_RESP;
        else                    cnt_n   = cnt - 4'd1;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // addr_n already holds the live address when WAIT=0 jumps IDLE->RESP,
  // so one read path serves both the latched and the direct case.
  assign capture  = (state_n == S_RESP) && (state != S_RESP);
  assign rd_fault = (addr_n[1:0] != 2'b00) || ((addr_n >> (IW + 2)) != '0);
  assign rd_word  = mem[addr_n[IW+1:2]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      instr_D <= '0;
      fault   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      if (capture) begin
        instr_D <= rd_fault ? '0 : rd_word;
        fault   <= rd_fault;
      end
    end
  end

  // Not reset: contents survive reset and loads are honoured in every state.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign stall_F     = ((state == S_IDLE) && req_valid && !flush) || (state == S_WAIT);
  assign instr_valid = (state == S_RESP) && !flush;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_imem_responder;

  localparam int W = 2;
  localparam int D = 64;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush, load_en;
  logic [63:0] addr;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        stall_F, instr_valid, fault;
  logic [31:0] instr_D;
  logic        stall0, valid0, fault0;
  logic [31:0] data0;

  logic [31:0] ref_mem [D];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_responder #(.N(64), .DEPTH(D), .WAIT(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .imem_addr_F(addr),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .stall_F(stall_F), .instr_valid(instr_valid), .instr_D(instr_D), .fault(fault)
  );

  imem_responder #(.N(64), .DEPTH(D), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .imem_addr_F(addr),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .stall_F(stall0), .instr_valid(valid0), .instr_D(data0), .fault(fault0)
  );

  // Returns {fault, word} for a byte address from the bench's memory image.
  function automatic logic [32:0] ref_read(input logic [63:0] a);
    if ((a % 4) != 0 || a >= 64'(4 * D)) return {1'b1, 32'h0};
    return {1'b0, ref_mem[int'(a >> 2)]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic load_word(input int i, input logic [31:0] d);
    load_en = 1'b1; load_addr = 6'(i); load_data = d;
    ref_mem[i] = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; load_en = 1'b0;
    addr = '0; load_addr = '0; load_data = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests++; if (stall_F !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_F); end
    tests++; if (instr_D !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr_D); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault); end
    tests++; if (valid0 !== 1'b0 || data0 !== 32'h0) begin fails++; $display("FAIL reset_w0: got %b/%h want 0/0", valid0, data0); end
    step();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < D; i++) load_word(i, $urandom);
  endtask

  task automatic test_basic_read();
    load_word(1, 32'h8B020020);
    do_reset();
    req_valid = 1'b1; addr = 64'd4;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      tests++; if (stall_F !== (c != 3)) begin fails++; $display("FAIL basic_stall c=%0d: got %b want %b", c, stall_F, c != 3); end
      tests++; if (instr_valid !== (c == 3)) begin fails++; $display("FAIL basic_valid c=%0d: got %b want %b", c, instr_valid, c == 3); end
      if (c == 3) begin
        tests++; if (instr_D !== 32'h8B020020 || fault !== 1'b0) begin fails++; $display("FAIL basic_data: got %h/%b want 8b020020/0", instr_D, fault); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = 32'hF8400001; w[1] = 32'h91000422; w[2] = 32'hB4000043;
    for (int i = 0; i < 3; i++) load_word(i, w[i]);
    do_reset();
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      addr = 64'((c / 4) * 4);
      @(negedge clk);
      tests++; if (instr_valid !== (c % 4 == 3)) begin fails++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, instr_valid, c % 4 == 3); end
      tests++; if (stall_F !== (c % 4 != 3)) begin fails++; $display("FAIL b2b_stall c=%0d: got %b want %b", c, stall_F, c % 4 != 3); end
      if (c % 4 == 3) begin
        tests++; if (instr_D !== w[c / 4]) begin fails++; $display("FAIL b2b_data c=%0d: got %h want %h", c, instr_D, w[c / 4]); end
      end
      step();
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 1'b1; addr = 64'd8;
    @(negedge clk);
    tests++; if (stall_F !== 1'b1) begin fails++; $display("FAIL flush_accept: got %b want 1", stall_F); end
    step();
    flush = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL flush_c1_valid: got %b want 0", instr_valid); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    tests++; if (stall_F !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL flush_c2_idle: got %b/%b want 0/0", stall_F, instr_valid); end
    req_valid = 1'b1; addr = 64'd127;
    @(negedge clk);
    tests++; if (stall_F !== 1'b1) begin fails++; $display("FAIL flush_reaccept: got %b want 1", stall_F); end
    for (int c = 3; c <= 5; c++) begin
      step();
      @(negedge clk);
      tests++; if (instr_valid !== (c == 5)) begin fails++; $display("FAIL flush_valid c=%0d: got %b want %b", c, instr_valid, c == 5); end
    end
    tests++; if (fault !== 1'b1 || instr_D !== 32'h0) begin fails++; $display("FAIL flush_fault: got %b/%h want 1/0", fault, instr_D); end
    step();
  endtask

  task automatic test_range_fault();
    logic [63:0] al [4];
    logic [32:0] e;
    al[0] = 64'd256; al[1] = 64'd252; al[2] = 64'h8000_0000_0000_0004; al[3] = 64'h102;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      req_valid = 1'b1; addr = al[i];
      e = ref_read(al[i]);
      repeat (3) step();
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1 || fault !== e[32] || instr_D !== e[31:0])
        begin fails++; $display("FAIL range a=%h: got %b/%b/%h want 1/%b/%h", al[i], instr_valid, fault, instr_D, e[32], e[31:0]); end
    end
  endtask

  task automatic test_wait0();
    logic [32:0] e;
    do_reset();
    req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      addr = 64'(20 + (c / 2) * 4);
      e = ref_read(addr);
      @(negedge clk);
      tests++; if (stall0 !== (c % 2 == 0)) begin fails++; $display("FAIL w0_stall c=%0d: got %b want %b", c, stall0, c % 2 == 0); end
      tests++; if (valid0 !== (c % 2 == 1)) begin fails++; $display("FAIL w0_valid c=%0d: got %b want %b", c, valid0, c % 2 == 1); end
      if (c % 2 == 1) begin
        tests++; if (data0 !== e[31:0] || fault0 !== e[32]) begin fails++; $display("FAIL w0_data c=%0d: got %h want %h", c, data0, e[31:0]); end
      end
      step();
    end
  endtask

  task automatic test_rbw();
    logic [31:0] old_w, new_w;
    old_w = ref_mem[9]; new_w = ~old_w;
    do_reset();
    req_valid = 1'b1; addr = 64'd36;
    for (int c = 0; c < 8; c++) begin
      load_en = (c == 2); load_addr = 6'd9; load_data = new_w;
      @(negedge clk);
      if (c == 3) begin
        tests++; if (instr_valid !== 1'b1 || instr_D !== old_w) begin fails++; $display("FAIL rbw_old: got %b/%h want 1/%h", instr_valid, instr_D, old_w); end
      end
      if (c == 7) begin
        tests++; if (instr_valid !== 1'b1 || instr_D !== new_w) begin fails++; $display("FAIL rbw_new: got %b/%h want 1/%h", instr_valid, instr_D, new_w); end
      end
      step();
      if (c == 2) ref_mem[9] = new_w;
    end
    load_en = 1'b0;
  endtask

  // Transaction model: an accepted fetch responds exactly W+1 cycles later with
  // the memory image as it stood just before the response edge.
  task automatic test_random();
    bit pend = 0;
    int resp_k = 0;
    logic [63:0] paddr = '0;
    logic [32:0] exp_r = '0;
    bit e_stall, e_valid;
    int r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      if (r < 6)       addr = {56'h0, 6'($urandom), 2'b00};
      else if (r < 8)  addr = {56'h0, 6'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 8) addr = {$urandom, $urandom} | 64'h100;
      else             addr = ($urandom_range(0, 1) != 0) ? 64'd256 : 64'd252;
      load_en   = ($urandom_range(0, 2) == 0);
      load_addr = ($urandom_range(0, 1) != 0) ? paddr[7:2] : 6'($urandom);
      load_data = $urandom;
      @(negedge clk);
      if (pend && k == resp_k) begin e_stall = 0; e_valid = !flush; end
      else if (pend)           begin e_stall = 1; e_valid = 0; end
      else                     begin e_stall = req_valid && !flush; e_valid = 0; end
      tests++; if (stall_F !== e_stall) begin fails++; $display("FAIL rnd_stall k=%0d: got %b want %b", k, stall_F, e_stall); end
      tests++; if (instr_valid !== e_valid) begin fails++; $display("FAIL rnd_valid k=%0d: got %b want %b", k, instr_valid, e_valid); end
      if (e_valid) begin
        tests++; if (fault !== exp_r[32] || instr_D !== exp_r[31:0])
          begin fails++; $display("FAIL rnd_data k=%0d: got %b/%h want %b/%h", k, fault, instr_D, exp_r[32], exp_r[31:0]); end
      end
      if (pend && (k == resp_k || flush)) pend = 0;
      else if (!pend && req_valid && !flush) begin pend = 1; paddr = addr; resp_k = k + W + 1; end
      if (pend && k == resp_k - 1) exp_r = ref_read(paddr);
      if (load_en) ref_mem[load_addr] = load_data;
      step();
    end
    load_en = 1'b0; req_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    fill_mem();
    test_basic_read();
    test_back_to_back();
    test_flush();
    test_range_fault();
    test_wait0();
    test_rbw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
